compound_assign_unit: RTL and testbench

- Command-driven responder that executes compound-assignment operations (=, +=, -=, *=, /=, %=, &=, |=, ^=, <<=, >>=, <<<=, >>>=) on a single accumulator register.
- Sits behind any sequencer that issues statement-style updates.
- All operations except divide and modulo complete in one cycle; divide and modulo run an iterative restoring divider.
- Uses a valid/ready command handshake and pulses a result-valid strobe when each operation completes.

---
 rtl/compound_assign_unit.sv | 121 ++++++++++++
 tb/tb_compound_assign_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/compound_assign_unit.sv
// compound_assign_unit: accumulator executing compound-assignment commands; optional COMPOUND_ASSIGN_SAT_EN saturates += and -=
module compound_assign_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_valid,
  output logic             o_div_by_zero,
  output logic             o_illegal
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DIV  = 1'b1;
  localparam int CW = $clog2(WIDTH);
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d, dbz_q, dbz_d, ill_q, ill_d, mod_q, mod_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next, quo_next, add_res, sub_res, sra, alu;
  logic             ge, is_div, illegal;
  // restoring divider: shift next dividend bit into the partial remainder each cycle
  assign trial    = {rem_q, quo_q[WIDTH-1]};
  assign ge       = trial >= {1'b0, dvs_q};
  assign rem_next = ge ? trial[WIDTH-1:0] - dvs_q : trial[WIDTH-1:0];
  assign quo_next = {quo_q[WIDTH-2:0], ge};
`ifdef COMPOUND_ASSIGN_SAT_EN
  logic [WIDTH:0] sum;
  assign sum     = {1'b0, acc_q} + {1'b0, i_operand};
  assign add_res = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  assign sub_res = (acc_q < i_operand) ? '0 : acc_q - i_operand;
`else
  assign add_res = acc_q + i_operand;
  assign sub_res = acc_q - i_operand;
`endif
  assign sra     = $signed(acc_q) >>> i_operand;
  assign is_div  = (i_op == 4'd4) || (i_op == 4'd5);
  assign illegal = i_op > 4'd12;
  assign alu = (i_op == 4'd0)  ? i_operand :
               (i_op == 4'd1)  ? add_res :
               (i_op == 4'd2)  ? sub_res :
               (i_op == 4'd3)  ? acc_q * i_operand :
               (i_op == 4'd6)  ? acc_q & i_operand :
               (i_op == 4'd7)  ? acc_q | i_operand :
               (i_op == 4'd8)  ? acc_q ^ i_operand :
               (i_op == 4'd9 || i_op == 4'd11) ? acc_q << i_operand :
               (i_op == 4'd10) ? acc_q >> i_operand :
               (i_op == 4'd12) ? sra : acc_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    mod_d   = mod_q;
    dbz_d   = dbz_q;
    ill_d   = ill_q;
    valid_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_valid && is_div) begin
        state_d = DIV;
        quo_d   = acc_q;
        rem_d   = '0;
        dvs_d   = i_operand;
        mod_d   = i_op[0];
        cnt_d   = '0;
      end else if (i_valid) begin
        acc_d   = alu;
        valid_d = 1'b1;
        dbz_d   = 1'b0;
        ill_d   = illegal;
      end
    end else begin
      quo_d = quo_next;
      rem_d = rem_next;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        acc_d   = mod_q ? rem_next : quo_next;
        valid_d = 1'b1;
        dbz_d   = dvs_q == '0;
        ill_d   = 1'b0;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      mod_q   <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      mod_q   <= mod_d;
      dbz_q   <= dbz_d;
      ill_q   <= ill_d;
      valid_q <= valid_d;
    end
  end
  assign o_ready       = state_q == IDLE;
  assign o_acc         = acc_q;
  assign o_valid       = valid_q;
  assign o_div_by_zero = dbz_q;
  assign o_illegal     = ill_q;
endmodule

// File: tb/tb_compound_assign_unit.sv
// tb_compound_assign_unit: table-driven directed checks of compound_assign_unit at WIDTH=8
module tb_compound_assign_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [3:0] i_op = '0;
  logic [7:0] i_operand = '0;
  logic [7:0] o_acc;
  logic       o_valid, o_div_by_zero, o_illegal;
  int checks = 0;
  int failures = 0;
  compound_assign_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_operand(i_operand), .o_acc(o_acc), .o_valid(o_valid),
    .o_div_by_zero(o_div_by_zero), .o_illegal(o_illegal)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] op;
    logic [7:0] operand;
    logic [7:0] acc;
    logic       dbz;
    logic       ill;
    int         lat;
  } vec_t;
`ifdef COMPOUND_ASSIGN_SAT_EN
  localparam logic [7:0] SUB_UF = 8'h00;
  localparam logic [7:0] ADD_OF = 8'hFF;
`else
  localparam logic [7:0] SUB_UF = 8'hFF;
  localparam logic [7:0] ADD_OF = 8'h03;
`endif
  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask
  // drive one command, then wait (bounded) for its o_valid pulse
  task automatic do_cmd(input logic [3:0] op, input logic [7:0] operand, output int lat, output int busy);
    @(negedge clk);
    i_valid = 1'b1;
    i_op = op;
    i_operand = operand;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    lat = 0;
    busy = 0;
    while (!o_valid && lat < 40) begin
      if (!o_ready) busy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  vec_t vecs[$];
  initial begin
    int lat, busy, n;
    vecs = '{
      '{4'd0,  8'd8,   8'd8,   1'b0, 1'b0, 0},
      '{4'd2,  8'd9,   SUB_UF, 1'b0, 1'b0, 0},
      '{4'd0,  8'hFE,  8'hFE,  1'b0, 1'b0, 0},
      '{4'd1,  8'd5,   ADD_OF, 1'b0, 1'b0, 0},
      '{4'd0,  8'd100, 8'd100, 1'b0, 1'b0, 0},
      '{4'd4,  8'd7,   8'd14,  1'b0, 1'b0, 8},
      '{4'd0,  8'd100, 8'd100, 1'b0, 1'b0, 0},
      '{4'd5,  8'd7,   8'd2,   1'b0, 1'b0, 8},
      '{4'd0,  8'h55,  8'h55,  1'b0, 1'b0, 0},
      '{4'd4,  8'd0,   8'hFF,  1'b1, 1'b0, 8},
      '{4'd0,  8'h55,  8'h55,  1'b0, 1'b0, 0},
      '{4'd5,  8'd0,   8'h55,  1'b1, 1'b0, 8},
      '{4'd1,  8'd1,   8'h56,  1'b0, 1'b0, 0},
      '{4'd0,  8'h80,  8'h80,  1'b0, 1'b0, 0},
      '{4'd12, 8'd3,   8'hF0,  1'b0, 1'b0, 0},
      '{4'd0,  8'h80,  8'h80,  1'b0, 1'b0, 0},
      '{4'd10, 8'd3,   8'h10,  1'b0, 1'b0, 0},
      '{4'd9,  8'd9,   8'h00,  1'b0, 1'b0, 0},
      '{4'd0,  8'h80,  8'h80,  1'b0, 1'b0, 0},
      '{4'd12, 8'd200, 8'hFF,  1'b0, 1'b0, 0},
      '{4'd14, 8'd0,   8'hFF,  1'b0, 1'b1, 0},
      '{4'd0,  8'd7,   8'd7,   1'b0, 1'b0, 0},
      '{4'd3,  8'd6,   8'd42,  1'b0, 1'b0, 0},
      '{4'd6,  8'h0F,  8'h0A,  1'b0, 1'b0, 0},
      '{4'd7,  8'h50,  8'h5A,  1'b0, 1'b0, 0},
      '{4'd8,  8'hFF,  8'hA5,  1'b0, 1'b0, 0},
      '{4'd11, 8'd1,   8'h4A,  1'b0, 1'b0, 0},
      '{4'd4,  8'd3,   8'd24,  1'b0, 1'b0, 8},
      '{4'd9,  8'd8,   8'h00,  1'b0, 1'b0, 0}
    };
    #12;
    check("reset acc", o_acc, 0);
    check("reset ready", o_ready, 1);
    check("reset valid", o_valid, 0);
    check("reset flags", {o_div_by_zero, o_illegal}, 0);
    @(negedge clk);
    rst = 1'b0;
    // back-to-back =5 then +=3
    @(negedge clk);
    i_valid = 1'b1;
    i_op = 4'd0;
    i_operand = 8'd5;
    @(posedge clk);
    #1;
    i_op = 4'd1;
    i_operand = 8'd3;
    check("b2b valid1", o_valid, 1);
    check("b2b acc1", o_acc, 5);
    check("b2b ready1", o_ready, 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("b2b valid2", o_valid, 1);
    check("b2b acc2", o_acc, 8);
    check("b2b ready2", o_ready, 1);
    @(posedge clk);
    #1;
    check("b2b valid drop", o_valid, 0);
    foreach (vecs[k]) begin
      do_cmd(vecs[k].op, vecs[k].operand, lat, busy);
      check($sformatf("vec%0d acc", k), o_acc, vecs[k].acc);
      check($sformatf("vec%0d dbz", k), o_div_by_zero, vecs[k].dbz);
      check($sformatf("vec%0d ill", k), o_illegal, vecs[k].ill);
      check($sformatf("vec%0d latency", k), lat, vecs[k].lat);
      check($sformatf("vec%0d busy", k), busy, vecs[k].lat);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d single pulse", k), o_valid, 0);
    end
    // i_valid held during division must be ignored
    do_cmd(4'd0, 8'd200, lat, busy);
    @(negedge clk);
    i_valid = 1'b1;
    i_op = 4'd4;
    i_operand = 8'd10;
    @(posedge clk);
    #1;
    i_op = 4'd0;
    i_operand = 8'd77;
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    i_valid = 1'b0;
    check("div ignore valid acc", o_acc, 20);
    check("div ignore valid lat", lat, 8);
    // reset three cycles into a division
    do_cmd(4'd0, 8'd100, lat, busy);
    @(negedge clk);
    i_valid = 1'b1;
    i_op = 4'd4;
    i_operand = 8'd7;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset acc", o_acc, 0);
    check("midreset ready", o_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (o_valid) n++;
    end
    check("midreset no pulse", n, 0);
    check("midreset acc hold", o_acc, 0);
    do_cmd(4'd0, 8'd9, lat, busy);
    check("post reset acc", o_acc, 9);
    check("post reset lat", lat, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
